// File: rtl/decim2_cascade_if.sv
// Sample handshake, control and status bundle for decim2_cascade_ctrl.
// The master drives samples and control; the slave is the decimator.
`timescale 1ns/1ps
interface decim2_cascade_if #(
  parameter int DATA_W = 16
);
  logic                     ce;
  logic                     clr;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] data_in;
  logic                     out_valid;
  logic signed [DATA_W-1:0] data_out;
  logic                     busy;

  modport master (
    output ce, clr, in_valid, data_in,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  ce, clr, in_valid, data_in,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/decim2_cascade_ctrl.sv
// Cascade of STAGES decimate-by-2 pairwise averagers sharing one adder,
// time-multiplexed one stage per clock.
//
// state | meaning
// IDLE  | waiting for a sample; an accepted sample is applied to stage 0
// BUSY  | carrying an average up the cascade, stage idx this clock
`timescale 1ns/1ps
module decim2_cascade_ctrl #(
  parameter int DATA_W = 16,
  parameter int STAGES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  decim2_cascade_if.slave bus
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] prev_q [STAGES];
  logic [STAGES-1:0]        phase_q;
  logic signed [DATA_W-1:0] work_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] data_out_q;
  logic                     out_valid_q;

  logic [IDX_W-1:0]         stage;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] avg;
  logic                     fire;
  logic                     pairs;
  logic                     last;
  logic                     flush;

  always_comb begin
    stage        = '0;
    x            = bus.data_in;
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    flush        = bus.ce & bus.clr;

    if (state_q == BUSY) begin
      stage    = idx_q;
      x        = work_q;
      bus.busy = 1'b1;
    end else begin
      bus.in_ready = bus.ce & ~bus.clr;
    end

    fire  = bus.ce & ~bus.clr & ((state_q == BUSY) | bus.in_valid);
    pairs = phase_q[stage];
    last  = (stage == IDX_W'(STAGES - 1));
    // Sign-extended sum cannot overflow; dropping the LSB is floor(sum/2).
    sum   = {x[DATA_W-1], x} + {prev_q[stage][DATA_W-1], prev_q[stage]};
    avg   = sum[DATA_W:1];

    if (flush) begin
      state_d = IDLE;
    end else if (fire) begin
      state_d = (pairs && !last) ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) prev_q[i] <= '0;
      phase_q     <= '0;
      work_q      <= '0;
      idx_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // The pulse drops on every edge, even with ce low.
      out_valid_q <= 1'b0;
      if (flush) begin
        for (int i = 0; i < STAGES; i++) prev_q[i] <= '0;
        phase_q <= '0;
      end else if (fire) begin
        if (!pairs) begin
          prev_q[stage]  <= x;
          phase_q[stage] <= 1'b1;
        end else begin
          phase_q[stage] <= 1'b0;
          if (last) begin
            data_out_q  <= avg;
            out_valid_q <= 1'b1;
          end else begin
            work_q <= avg;
            idx_q  <= stage + 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_decim2_cascade_ctrl.sv
// Scoreboard bench: three decimators (STAGES=1,2,3) driven by directed vectors;
// expected outputs are queued at issue and popped by a per-output monitor.
`timescale 1ns/1ps
module tb_decim2_cascade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, clr, v;
  logic [15:0] d;
  int          sel;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int acc_n[3];
  int acc_cyc[3];
  int out_n[3];
  int out_cyc[3];
  int out_acc[3];
  int busy_run = 0;
  bit busy_chk = 1'b1;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] qc[$];

  logic [15:0] t2_in[6]  = '{16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
  logic [15:0] t2_exp[3] = '{16'hFFFE, 16'h7FFF, 16'h8000};
  logic [15:0] t5_in[8]  = '{16'hFFF9, 16'd4, 16'd9, 16'd12, 16'd100, 16'hFFFD, 16'd0, 16'd1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decim2_cascade_if #(.DATA_W(16)) ifa ();
  decim2_cascade_if #(.DATA_W(16)) ifb ();
  decim2_cascade_if #(.DATA_W(16)) ifc ();

  assign ifa.ce = ce;  assign ifa.clr = clr;  assign ifa.data_in = d;
  assign ifb.ce = ce;  assign ifb.clr = clr;  assign ifb.data_in = d;
  assign ifc.ce = ce;  assign ifc.clr = clr;  assign ifc.data_in = d;
  assign ifa.in_valid = v && (sel == 0);
  assign ifb.in_valid = v && (sel == 1);
  assign ifc.in_valid = v && (sel == 2);

  decim2_cascade_ctrl #(.DATA_W(16), .STAGES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  decim2_cascade_ctrl #(.DATA_W(16), .STAGES(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  decim2_cascade_ctrl #(.DATA_W(16), .STAGES(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic rdy(input int k);
    case (k)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  task automatic got(input int k, input logic [15:0] act);
    logic [15:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    out_n[k]++;
    out_cyc[k] = cyc;
    out_acc[k] = acc_n[k];
    case (k)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      chk($sformatf("data_out_dut%0d", k), act, e);
    end else begin
      checks++;
      $display("FAIL unexpected_output dut%0d: got 0x%0h expected no output", k, act);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.out_valid) got(0, ifa.data_out);
    if (ifb.out_valid) got(1, ifb.data_out);
    if (ifc.out_valid) begin
      if (busy_chk) chk("busy_before_pulse", busy_run, 2);
      got(2, ifc.data_out);
    end
    busy_run = ifc.busy ? busy_run + 1 : 0;
  end

  task automatic send(input int k, input logic [15:0] val, output int waited);
    int n;
    n = 0;
    @(negedge clk);
    sel = k; v = 1'b1; d = val;
    while (!rdy(k) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("accept_timeout_dut%0d", k), 0, 1);
    @(posedge clk);
    #1;
    v = 1'b0;
    acc_n[k]++;
    acc_cyc[k] = cyc;
    waited = n;
  endtask

  task automatic wait_out(input int k, input int target, input int lat);
    int n;
    n = 0;
    while (out_n[k] < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (out_n[k] < target) chk($sformatf("output_timeout_dut%0d", k), out_n[k], target);
    else chk($sformatf("latency_dut%0d", k), out_cyc[k] - acc_cyc[k], lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    int abase;
    rst_n = 1'b0; ce = 1'b1; clr = 1'b0; v = 1'b0; d = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {ifa.out_valid, ifb.out_valid, ifc.out_valid}, 0);
    chk("rst_data_out", {ifa.data_out, ifb.data_out}, 0);
    chk("rst_busy", {ifa.busy, ifb.busy, ifc.busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {ifa.in_ready, ifb.in_ready, ifc.in_ready}, 3'b111);

    // STAGES=2: 100,200 -> 150; 300,500 -> 400; then 275
    qb.push_back(16'd275);
    send(1, 16'd100, w); chk("t1_wait1", w, 0);
    send(1, 16'd200, w); chk("t1_wait2", w, 0);
    send(1, 16'd300, w); chk("t1_wait3", w, 1);
    send(1, 16'd500, w); chk("t1_wait4", w, 0);
    @(negedge clk);
    chk("t1_ready_low", ifb.in_ready, 0);
    chk("t1_busy", ifb.busy, 1);
    @(negedge clk);
    chk("t1_ready_back", ifb.in_ready, 1);
    wait_out(1, 1, 1);
    @(negedge clk);
    chk("t1_pulse_width", ifb.out_valid, 0);
    chk("t1_data_hold", ifb.data_out, 16'd275);

    // STAGES=1: floor rounding and extremes
    for (int i = 0; i < 3; i++) begin
      qa.push_back(t2_exp[i]);
      send(0, t2_in[2*i], w);   chk("t2_wait", w, 0);
      send(0, t2_in[2*i+1], w); chk("t2_wait", w, 0);
      wait_out(0, i + 1, 0);
    end

    // STAGES=3: two full windows of 0x4000
    abase = acc_n[2];
    for (int blk = 0; blk < 2; blk++) begin
      qc.push_back(16'h4000);
      for (int i = 0; i < 8; i++) send(2, 16'h4000, w);
      wait_out(2, blk + 1, 2);
      chk("t3_spacing", out_acc[2] - abase, 8 * (blk + 1));
    end
    chk("t3_pulse_count", out_n[2], 2);

    // STAGES=2: clr discards the three pending samples
    base = out_n[1];
    send(1, 16'd1000, w);
    send(1, 16'd3000, w);
    send(1, 16'd5000, w);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("t4_ready_clr", ifb.in_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    chk("t4_no_output", out_n[1], base);
    qb.push_back(16'd25);
    send(1, 16'd10, w);
    send(1, 16'd20, w);
    send(1, 16'd30, w);
    send(1, 16'd40, w);
    wait_out(1, base + 1, 1);

    // STAGES=3: ce gap while BUSY at idx=1
    busy_chk = 1'b0;
    base = out_n[2];
    qc.push_back(16'd14);
    for (int i = 0; i < 8; i++) send(2, t5_in[i], w);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_ready_gap", ifc.in_ready, 0);
      chk("t5_busy_gap", ifc.busy, 1);
      @(posedge clk);
    end
    chk("t5_no_progress", out_n[2], base);
    #1;
    ce = 1'b1;
    wait_out(2, base + 1, 7);
    busy_chk = 1'b1;

    // STAGES=3: reset mid-cascade, then a clean window of 8s
    base = out_n[2];
    send(2, 16'd1000, w);
    send(2, 16'd1000, w);
    send(2, 16'd2000, w);
    send(2, 16'd2000, w);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ifc.out_valid, 0);
    chk("t6_rst_data", ifc.data_out, 0);
    chk("t6_rst_busy", ifc.busy, 0);
    chk("t6_rst_data_b", ifb.data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", ifc.in_ready, 1);
    chk("t6_no_output", out_n[2], base);
    qc.push_back(16'd8);
    for (int i = 0; i < 8; i++) send(2, 16'd8, w);
    wait_out(2, base + 1, 2);

    repeat (4) @(negedge clk);
    chk("queues_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decim2_cascade_ctrl.md
Name: decim2_cascade_ctrl

Overview:
- Sequencer for a cascade of STAGES decimate-by-2 pairwise-average stages that share one averaging adder.
- Accepts Q15 samples over a valid/ready handshake and schedules one stage operation per clock.
- Emits one averaged, decimated sample for every 2^STAGES accepted inputs.
- Sits between the sigma-delta demodulator output and downstream consumers; replaces a chain of per-stage averaging filters with a single time-multiplexed datapath.

Parameters:
- DATA_W, 16, sample width (signed fixed point, Q15 at default).
- STAGES, 3, number of cascaded decimate-by-2 stages; legal range 1..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state frozen while low
- clr  in  1  synchronous flush of all stage state
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- data_in  in  DATA_W  signed input sample
- out_valid  out  1  single-cycle pulse, data_out valid
- data_out  out  DATA_W  signed decimated output sample
- busy  out  1  high while the FSM is in BUSY

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low, on rst_n. All of the following clear to 0: prev[0..STAGES-1], phase[0..STAGES-1], work, idx, data_out, out_valid. State goes to IDLE. This applies at any time, including mid-cascade.
- Per-stage state: prev[s] (DATA_W) holds the first sample of a pair; phase[s] is 1 when prev[s] holds an unpaired sample.
- Shared op on stage s with operand x:
  - phase[s]=0: prev[s]<=x, phase[s]<=1; cascade terminates.
  - phase[s]=1: avg=(prev[s]+x)>>>1, computed at DATA_W+1 bits signed (floor rounding toward -inf, no overflow); phase[s]<=0; avg goes to stage s+1.
- FSM states:
  - IDLE: in_ready=ce&~clr.
    - On an edge with in_valid&in_ready, apply the op to stage 0 with x=data_in.
    - If it pairs and STAGES>1: work<=avg, idx<=1, go to BUSY.
    - If it pairs and STAGES=1: data_out<=avg, out_valid<=1.
    - Otherwise stay in IDLE.
  - BUSY: in_ready=0, busy=1. Each ce edge applies the op to stage idx with x=work.
    - Pairing at idx<STAGES-1: work<=avg, idx<=idx+1.
    - Pairing at idx=STAGES-1: data_out<=avg, out_valid<=1, go to IDLE.
    - Store (no pair): go to IDLE.
- Latency: the output-producing acceptance edge is edge 1; out_valid is high in the cycle following edge STAGES.
- Worst-case in_ready low time: STAGES-1 cycles.
- out_valid: high for exactly one cycle. It clears on the next clk edge regardless of ce. data_out holds its last value until the next output.
- ce=0: no state, prev, phase, idx or work updates. in_ready=0. A BUSY cascade resumes unchanged when ce returns.
- clr=1 (with ce=1): clears all prev and phase, aborts any BUSY cascade to IDLE, forces out_valid<=0. Any input offered in the same cycle is not accepted. data_out is retained.
- in_valid while in_ready=0: ignored. The source must hold it; no sample is lost or duplicated.

Test Plan:
- STAGES=2, inputs 100,200,300,500 with back-to-back in_valid -> in_ready low 1 cycle after 2nd and 4th accept; single out_valid pulse 2 cycles after 4th accept with data_out=275 (stage-0 values 150, 400).
- STAGES=1, inputs -1,-2 -> data_out=-2 (floor of -1.5); inputs 32767,32767 -> 32767 (no overflow); inputs -32768,-32768 -> -32768.
- STAGES=3, 16 inputs of 0x4000 -> exactly two out_valid pulses, each data_out=16384, spaced by 8 accepted inputs; busy high 2 cycles before each pulse.
- STAGES=2, accept 3 samples, pulse clr, then feed 10,20,30,40 -> one output of 25, no contribution from the pre-clr samples.
- STAGES=3, drop ce low for 5 cycles while BUSY at idx=1 -> in_ready=0 and no progress during the gap; the cascade completes with the correct value after ce returns.
- STAGES=3, assert rst_n low while BUSY -> all outputs 0 immediately; after release, 8 inputs of 8 -> data_out=8 with no stale pairing.
